// File: rtl/eth_frame_gen.sv
// -----------------------------------------------------------------------------
// eth_frame_gen
//   Synthetic Ethernet-style traffic source on an 8-bit AXI-Stream master.
//   It emits frames of a configurable length, with a counting payload and a
//   configurable idle gap between frames. A run optionally stops after a fixed
//   number of frames.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous reset, active-high, overrides all other inputs
//   enable         1 = run traffic, 0 = stop once the current frame finishes
//   frame_size     frame length in bytes, sampled at frame start, clamped to
//                  the range 60..1514
//   frame_gap      idle cycles between frames, sampled at the tlast handshake
//   frame_count    frames per run (0 = unlimited), sampled at run start
//   m_axis_tdata   payload byte: (byte index + frame sequence) mod 256
//   m_axis_tvalid  AXIS valid
//   m_axis_tlast   last byte of the frame
//   m_axis_tready  AXIS ready from the MAC
//   busy           high in SEND or GAP
//   done           high in DONE (frame limit reached)
//   frames_sent    frames completed in the current run
//
// FSM states
//   state  | meaning
//   IDLE   | no traffic; frames_sent holds the last run's total
//   SEND   | streaming bytes of a frame
//   GAP    | idle gap between frames, gap_cnt counts down to 1
//   DONE   | frame limit reached; waits for enable to drop
// -----------------------------------------------------------------------------
module eth_frame_gen #(
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [15:0]              frame_size,
  input  logic [15:0]              frame_gap,
  input  logic [C_COUNT_WIDTH-1:0] frame_count,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     done,
  output logic [C_COUNT_WIDTH-1:0] frames_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] MIN_SIZE = 16'd60;
  localparam logic [15:0] MAX_SIZE = 16'd1514;

  state_t                   state, state_nxt;
  logic [15:0]              byte_idx, byte_idx_nxt;
  logic [15:0]              size_r, size_nxt;
  logic [15:0]              gap_cnt, gap_cnt_nxt;
  logic [C_COUNT_WIDTH-1:0] count_r, count_nxt;
  logic [C_COUNT_WIDTH-1:0] sent_nxt;
  logic [C_COUNT_WIDTH-1:0] sent_inc;
  logic [7:0]               tdata_nxt;
  logic                     tvalid_nxt, tlast_nxt;
  logic                     busy_nxt, done_nxt;
  logic                     start_frame;
  logic [7:0]               start_seq;

  function automatic logic [15:0] clamp_size(input logic [15:0] s);
    if (s < MIN_SIZE)      return MIN_SIZE;
    else if (s > MAX_SIZE) return MAX_SIZE;
    else                   return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_idx      <= '0;
      size_r        <= '0;
      gap_cnt       <= '0;
      count_r       <= '0;
      frames_sent   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      byte_idx      <= byte_idx_nxt;
      size_r        <= size_nxt;
      gap_cnt       <= gap_cnt_nxt;
      count_r       <= count_nxt;
      frames_sent   <= sent_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    size_nxt     = size_r;
    gap_cnt_nxt  = gap_cnt;
    count_nxt    = count_r;
    sent_nxt     = frames_sent;
    tdata_nxt    = m_axis_tdata;
    tvalid_nxt   = m_axis_tvalid;
    tlast_nxt    = m_axis_tlast;
    sent_inc     = frames_sent + 1'b1;
    start_frame  = 1'b0;
    start_seq    = 8'd0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          sent_nxt    = '0;
          count_nxt   = frame_count;
          start_frame = 1'b1;
          start_seq   = 8'd0;
        end
      end

      S_SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            sent_nxt  = sent_inc;
            tlast_nxt = 1'b0;
            if ((count_r != '0) && (sent_inc == count_r)) begin
              state_nxt  = S_DONE;
              tvalid_nxt = 1'b0;
            end else if (!enable) begin
              state_nxt  = S_IDLE;
              tvalid_nxt = 1'b0;
            end else if (frame_gap == 16'd0) begin
              start_frame = 1'b1;
              start_seq   = sent_inc[7:0];
            end else begin
              state_nxt   = S_GAP;
              gap_cnt_nxt = frame_gap;
              tvalid_nxt  = 1'b0;
            end
          end else begin
            byte_idx_nxt = byte_idx + 16'd1;
            tdata_nxt    = m_axis_tdata + 8'd1;
            tlast_nxt    = ((byte_idx + 16'd1) == (size_r - 16'd1));
          end
        end
      end

      S_GAP: begin
        // Terminal count at 1 so tvalid rises right after the last idle cycle.
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (gap_cnt == 16'd1) begin
          start_frame = 1'b1;
          start_seq   = frames_sent[7:0];
        end else begin
          gap_cnt_nxt = gap_cnt - 16'd1;
        end
      end

      S_DONE: begin
        if (!enable) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    // The clamped minimum of 60 bytes means the first byte is never the last.
    if (start_frame) begin
      state_nxt    = S_SEND;
      size_nxt     = clamp_size(frame_size);
      byte_idx_nxt = 16'd0;
      gap_cnt_nxt  = 16'd0;
      tdata_nxt    = start_seq;
      tvalid_nxt   = 1'b1;
      tlast_nxt    = 1'b0;
    end

    busy_nxt = (state_nxt == S_SEND) || (state_nxt == S_GAP);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: doc/eth_frame_gen.md
ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 Parameter C_COUNT_WIDTH, default 32, width of frame_count and frames_sent.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 enable  input  1  level; 1 = run traffic, 0 = stop after current frame.
REQ-005 frame_size  input  16  frame length in bytes, sampled at frame start.
REQ-006 frame_gap  input  16  idle cycles between frames, sampled at tlast handshake.
REQ-007 frame_count  input  C_COUNT_WIDTH  frames per run; 0 = unlimited; sampled at run start.
REQ-008 m_axis_tdata  output  8  payload byte.
REQ-009 m_axis_tvalid  output  1  AXIS valid.
REQ-010 m_axis_tlast  output  1  last byte of frame.
REQ-011 m_axis_tready  input  1  AXIS ready from MAC.
REQ-012 busy  output  1  high in SEND or GAP.
REQ-013 done  output  1  high in DONE.
REQ-014 frames_sent  output  C_COUNT_WIDTH  frames completed in current run.

Function
REQ-015 FSM states IDLE, SEND, GAP, DONE; all outputs registered.
REQ-016 IDLE: enable=1 at cycle N -> SEND, frames_sent cleared, frame_count latched, tvalid=1 from N+1.
REQ-017 Frame start: effective size = frame_size clamped to [60,1514]; byte index i starts at 0.
REQ-018 tdata for byte i = (i + frame_seq) mod 256, frame_seq = frames_sent[7:0] at frame start.
REQ-019 Byte advances only on tvalid&tready; tdata, tlast, tvalid held stable while tvalid&~tready.
REQ-020 tlast=1 exactly on byte i = size-1; tvalid never deasserts mid-frame.
REQ-021 On tlast handshake: frames_sent += 1, wraps at 2^C_COUNT_WIDTH.
REQ-022 After tlast handshake, priority: limit reached (frame_count!=0 and new frames_sent==frame_count) -> DONE; else enable=0 -> IDLE; else gap=0 -> SEND; else -> GAP.
REQ-023 gap=0: first byte of next frame valid in cycle after tlast handshake (back-to-back).
REQ-024 GAP: tvalid=0 for exactly frame_gap cycles after tlast handshake, then SEND with tvalid=1; enable=0 during GAP -> IDLE next cycle.
REQ-025 enable=0 during SEND: current frame completes fully; no truncation.
REQ-026 DONE: tvalid=0, done=1; stays until enable=0, then IDLE; frames_sent held.
REQ-027 frame_size/frame_gap changes mid-frame/mid-gap have no effect on the frame/gap in progress.
REQ-028 frames_sent readable at all times; held in IDLE until next run start.

Reset
REQ-029 rst=1 at clock edge: state IDLE, tvalid=0, tlast=0, tdata=0, busy=0, done=0, frames_sent=0, byte index and gap counter 0.
REQ-030 rst mid-frame aborts the frame immediately (tvalid=0 next cycle); no tlast emitted.
REQ-031 rst has priority over all other inputs.

Verification
REQ-032 size=64, gap=0, count=3, tready=1 -> 192 consecutive valid cycles, tlast at bytes 63/127/191, first bytes 0x00/0x01/0x02, done=1, frames_sent=3.
REQ-033 size=10 -> 60-byte frame; size=2000 -> 1514-byte frame.
REQ-034 size=60, gap=12, count=2 -> exactly 12 tvalid=0 cycles between tlast handshake and next first byte.
REQ-035 tready random 50% -> tdata/tlast stable across every stalled cycle; byte sequence unbroken; frame counts match.
REQ-036 count=0, enable dropped at byte 20 of frame 5 -> frame 5 completes (tlast), IDLE, frames_sent=5, done=0.
REQ-037 rst asserted at byte 30 -> next cycle tvalid=0, frames_sent=0, state IDLE; re-enable restarts at byte 0 with seq 0x00.
